// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences a uart_rx receiver and buffers its good bytes.
//
// The FSM gates rx_en from the host enable. Each rx_done is a frame end.
// Good frames are written into a show-ahead FIFO with a valid/ready read port.
// Errored frames are dropped and counted, and a byte dropped on a full FIFO
// sets a sticky overrun flag. After a burst, an idle-line timeout pulses once.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   enable            host enable for reception
//   clr_status        pulse; clears overrun and err_cnt (FIFO untouched)
//   rx_en             enable to uart_rx (registered decode of state)
//   rx_busy           uart_rx busy flag
//   rx_done           uart_rx done pulse; qualifies rx_data / rx_err
//   rx_err            uart_rx stop-bit error
//   rx_data           uart_rx received byte
//   out_data          FIFO head (show-ahead, don't-care while empty)
//   out_valid         FIFO non-empty
//   out_ready         consumer accepts head when out_valid=1
//   level             FIFO occupancy, 0..DEPTH
//   overrun           sticky: good byte dropped on full FIFO
//   err_cnt           saturating count of errored frames
//   idle              single-cycle idle-timeout pulse
module uart_rx_ctrl #(
    parameter int DEPTH       = 8,
    parameter int IDLE_CYCLES = 208_320
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     clr_status,
    output logic                     rx_en,
    input  logic                     rx_busy,
    input  logic                     rx_done,
    input  logic                     rx_err,
    input  logic [7:0]               rx_data,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    output logic [7:0]               err_cnt,
    output logic                     idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(IDLE_CYCLES) + 1;

    typedef enum logic [1:0] {
        OFF,
        ARM,
        RX
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_rx_en;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [LW-1:0]   w_level_next;
    logic            r_out_valid;
    logic            r_overrun;
    logic [7:0]      r_err_cnt;

    logic [CW-1:0]   r_idle_cnt;
    logic            r_idle;
    logic            r_byte_seen;

    logic            w_push_req;
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic            w_idle_run;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= OFF;
            r_rx_en <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rx_en <= (w_state_next != OFF);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            OFF: if (enable) w_state_next = ARM;
            ARM: begin
                if (!enable)      w_state_next = OFF;
                else if (rx_done) w_state_next = ARM;  // done coinciding with busy ends the frame here
                else if (rx_busy) w_state_next = RX;
            end
            RX:  if (rx_done) w_state_next = enable ? ARM : OFF;
            default: w_state_next = OFF;
        endcase
    end

    // ---------------- FIFO ----------------
    assign w_push_req = rx_done & ~rx_err;
    assign w_pop      = (r_level != '0) & out_ready;
    assign w_full     = (r_level == LW'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push     = w_push_req & (~w_full | w_pop);

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop)      w_level_next = r_level + LW'(1);
        else if (!w_push && w_pop) w_level_next = r_level - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level     <= w_level_next;
            r_out_valid <= (w_level_next != '0);
        end
    end

    // ---------------- status ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
            r_err_cnt <= '0;
        end else if (clr_status) begin
            r_overrun <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_push_req && w_full && !w_pop) r_overrun <= 1'b1;
            if (rx_done && rx_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    // ---------------- idle timer ----------------
    // Runs only while staying in ARM with a quiet line after a good byte.
    assign w_idle_run = (r_state == ARM) && (w_state_next == ARM) && r_byte_seen
                        && !rx_busy && !rx_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt  <= '0;
            r_idle      <= 1'b0;
            r_byte_seen <= 1'b0;
        end else begin
            r_idle <= 1'b0;
            if (w_idle_run) begin
                if (r_idle_cnt == CW'(IDLE_CYCLES - 1)) begin
                    r_idle      <= 1'b1;
                    r_idle_cnt  <= '0;
                    r_byte_seen <= 1'b0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + CW'(1);
                end
            end else begin
                r_idle_cnt <= '0;
            end
            if (w_push_req) r_byte_seen <= 1'b1;
        end
    end

    assign rx_en     = r_rx_en;
    assign out_data  = r_mem[r_rd_ptr];
    assign out_valid = r_out_valid;
    assign level     = r_level;
    assign overrun   = r_overrun;
    assign err_cnt   = r_err_cnt;
    assign idle      = r_idle;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that sequences the uart_rx receiver and buffers its output. It gates rx_en from a host enable and monitors busy/done/err. Good bytes go into an internal FIFO with a valid/ready read port. The block also keeps an overrun flag, a frame-error counter and an idle-line timeout pulse. It sits between uart_rx and the host/bus logic.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2.
IDLE_CYCLES, 208_320, clk cycles in ARM after the last received byte before idle pulses (20 bit times at 100 MHz / 9600 baud).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; one clock; reset is asynchronous and active-high.
enable  in  1  host enable for reception.
clr_status  in  1  single-cycle pulse; clears overrun and err_cnt.
rx_en  out  1  enable to uart_rx.
rx_busy  in  1  uart_rx busy flag.
rx_done  in  1  uart_rx single-cycle done pulse; rx_data and rx_err are valid in the same cycle.
rx_err  in  1  uart_rx stop-bit error, qualified by rx_done.
rx_data  in  8  uart_rx received byte.
out_data  out  8  FIFO head (show-ahead).
out_valid  out  1  FIFO non-empty.
out_ready  in  1  consumer accepts head when out_valid=1.
level  out  $clog2(DEPTH)+1  FIFO occupancy.
overrun  out  1  sticky: a good byte was dropped because the FIFO was full.
err_cnt  out  8  saturating count of frames with rx_err=1.
idle  out  1  single-cycle idle-timeout pulse.

Behaviour:
- Reset values (async assert): state=OFF, rx_en=0, out_valid=0, level=0, FIFO pointers=0, overrun=0, err_cnt=0, idle=0, idle counter=0, byte_seen=0. out_data is don't-care while empty.
- Output timing: all outputs registered. rx_en is a registered decode of state.
- FSM:
  - OFF: rx_en=0. Go to ARM when enable=1.
  - ARM: rx_en=1. Go to OFF if enable=0. Otherwise go to RX when rx_busy=1.
  - RX: rx_en=1. On rx_done, go to ARM if enable=1, else go to OFF.
  - enable falling mid-frame in RX does not abort; the frame completes first.
  - rx_done outside RX (e.g. in ARM when busy and done coincide) is still processed as a frame end. The FSM then stays in or returns to ARM.
- Frame end (rx_done=1):
  - rx_err=0: push rx_data. If the FIFO is full and no pop happens that cycle, drop the byte and set overrun=1.
  - rx_err=1: drop the byte and increment err_cnt, saturating at 255.
  - Either case sets byte_seen=1 only for a good byte.
- Push latency: a byte pushed on an rx_done cycle appears on out_data with out_valid=1 the next cycle.
- Pop: occurs when out_valid & out_ready. The new head is visible the next cycle.
- Simultaneous push and pop:
  - level is unchanged.
  - When full, the push is accepted and overrun is not set.
  - When empty, only the push happens.
- Pointers: log2(DEPTH) bits, natural wrap-around. level counts 0..DEPTH.
- clr_status:
  - Clears overrun and err_cnt to 0.
  - It wins over a same-cycle set or increment.
  - It does not affect the FIFO.
- Idle timer:
  - Counts only in ARM with byte_seen=1. Reset to 0 on any rx_busy, rx_done or exit from ARM.
  - On reaching IDLE_CYCLES-1: idle=1 for one cycle, counter=0, byte_seen=0.
  - Result: one idle pulse per burst.
- Disable (OFF): the FIFO contents are retained and remain readable. Status is retained.
- Async rst mid-frame: all state returns to reset values immediately. A frame in progress is lost.

Test Plan:
- Reset then enable=1 -> rx_en=1 one cycle after the enable edge. Drive frame 8'hD6 (rx_err=0) -> out_valid=1, out_data=8'hD6, level=1 the cycle after rx_done. Pulse out_ready -> level=0.
- Two frames 8'hD6 then 8'hD4 with out_ready=0 -> level=2, reads in order D6 then D4. err_cnt=0, overrun=0.
- Fill with DEPTH=8 good bytes 0x01..0x08, out_ready=0, then a 9th byte 0x09 -> level=8, overrun=1, head=0x01. Repeat with out_ready=1 on the 9th rx_done cycle -> no overrun, 0x09 stored, level=8. clr_status -> overrun=0.
- Three frames with rx_err=1 -> FIFO empty, err_cnt=3. Force 260 error frames -> err_cnt=255. clr_status coinciding with an error frame -> err_cnt=0.
- enable=0 mid-frame (RX) -> rx_en stays 1 until rx_done. Byte 0xA5 stored. Then state=OFF, rx_en=0, FIFO still readable.
- With IDLE_CYCLES=100: one byte, then line idle -> exactly one idle pulse 100 cycles after return to ARM, and no further pulse. Assert rst at cycle 50 of a frame -> rx_en=0, level=0, err_cnt=0 immediately.
